dmem_arbiter: RTL and testbench

Shares the single-port data memory between the core's load/store stage and an external requester (debug/DMA loader). Sequences each access over a fixed memory latency and latches the payload at grant. Drives a stall back to the pipeline while the core's access is pending. Sits between LS_unit and Data_mem; the core's stall_MW/stall logic ORs in core_stall.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/arb_rr2.sv | 37 +++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types.
// States, owner encoding and latency counter width.
package dmem_arb_pkg;

  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CORE,
    OWN_EXT
  } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick.
// The requester not granted last time wins a tie.
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req0,
  input  logic   req1,
  input  logic   grant_en,
  output owner_t winner
);

  owner_t last_q;
  owner_t last_d;

  // Winner selection and last-grant update.
  always_comb begin
    winner = OWN_CORE;
    if (req0 && req1) begin
      winner = (last_q == OWN_CORE) ? OWN_EXT : OWN_CORE;
    end else if (req1) begin
      winner = OWN_EXT;
    end
    last_d = grant_en ? winner : last_q;
  end

  // Last-grant register; EXT after reset so CORE wins first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= OWN_EXT;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: core load/store vs external requester.
// Fixed-latency access sequencing with payload latched at grant.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [3:0]        core_mask,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_done,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [3:0]        ext_mask,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              we_q, we_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] erd_q, erd_d;

  logic   in_access;
  logic   in_done;
  logic   arb_req0;
  logic   arb_req1;
  logic   grant;
  owner_t winner;

  assign in_access = (state_q == ACCESS);
  assign in_done   = (state_q == DONE);

  // The completing owner is masked so it is never re-granted from DONE.
  assign arb_req0 = core_req & ~(in_done & (owner_q == OWN_CORE));
  assign arb_req1 = ext_req & ~(in_done & (owner_q == OWN_EXT));
  assign grant    = ~in_access & (arb_req0 | arb_req1);

  arb_rr2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req0     (arb_req0),
    .req1     (arb_req1),
    .grant_en (grant),
    .winner   (winner)
  );

  // Next-state, payload latch and read-data capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    we_d    = we_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    erd_d   = erd_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (grant) begin
          state_d = ACCESS;
          owner_d = winner;
          lat_d   = LAT_W'(MEM_LAT - 1);
          if (winner == OWN_EXT) begin
            we_d    = ext_we;
            mask_d  = ext_mask;
            addr_d  = ext_addr;
            wdata_d = ext_wdata;
          end else begin
            we_d    = core_we;
            mask_d  = core_mask;
            addr_d  = core_addr;
            wdata_d = core_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (lat_q == '0) begin
          state_d = DONE;
          if (owner_q == OWN_EXT) begin
            erd_d = mem_rdata;
          end else begin
            crd_d = mem_rdata;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CORE;
      lat_q   <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      erd_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      erd_q   <= erd_d;
    end
  end

  assign mem_en     = in_access;
  assign mem_we     = in_access & we_q;
  assign mem_mask   = in_access ? mask_q : '0;
  assign mem_addr   = in_access ? addr_q : '0;
  assign mem_wdata  = in_access ? wdata_q : '0;
  assign core_done  = in_done & (owner_q == OWN_CORE);
  assign ext_done   = in_done & (owner_q == OWN_EXT);
  assign ext_gnt    = in_access & (owner_q == OWN_EXT);
  assign core_stall = core_req & ~core_done;
  assign core_rdata = crd_q;
  assign ext_rdata  = erd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// dmem_arbiter bench: directed vectors with a done-driven scoreboard.
// Memory read data comes from a fixed address-to-data table.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        ext;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        core_req, core_we;
  logic [3:0]  core_mask;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_done, core_stall;
  logic        ext_req, ext_we;
  logic [3:0]  ext_mask;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_done;
  logic        mem_en, mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  dmem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MEM_LAT (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_mask  (core_mask),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_done  (core_done),
    .core_stall (core_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_mask   (ext_mask),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rdata  (ext_rdata),
    .ext_done   (ext_done),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_mask   (mem_mask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h100: rd_model = 32'hDEADBEEF;
      32'h300: rd_model = 32'hCAFEF00D;
      32'h400: rd_model = 32'h0BADC0DE;
      32'h500: rd_model = 32'h55555555;
      default: rd_model = a ^ 32'h5A5A5A5A;
    endcase
  endfunction

  assign mem_rdata = rd_model(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic ext, input logic c,
                      input logic [31:0] d);
    exp_t e;
    e.ext  = ext;
    e.chk  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic rst();
    go();
    reset    = 1'b1;
    core_req = 1'b0;
    ext_req  = 1'b0;
    go();
    go();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every done pulse retires one expected entry.
  always @(negedge clk) begin
    if (core_done || ext_done) begin
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: core_done %b ext_done %b want none",
                 core_done, ext_done);
      end else begin
        e = sb.pop_front();
        if (core_done && ext_done) begin
          n_fail++;
          $display("FAIL sb_both_done: got 1/1 want one");
        end else if (ext_done !== e.ext) begin
          n_fail++;
          $display("FAIL sb_owner: got ext=%b want ext=%b", ext_done, e.ext);
        end else if (e.chk) begin
          if ((e.ext ? ext_rdata : core_rdata) !== e.data) begin
            n_fail++;
            $display("FAIL sb_rdata: got %h want %h",
                     e.ext ? ext_rdata : core_rdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_mask  = 4'hF;
    core_addr  = '0;
    core_wdata = '0;
    ext_req    = 1'b0;
    ext_we     = 1'b0;
    ext_mask   = 4'hF;
    ext_addr   = '0;
    ext_wdata  = '0;

    // Reset with both requests high; core wins first.
    go();
    reset     = 1'b1;
    core_req  = 1'b1;
    core_addr = 32'h100;
    ext_req   = 1'b1;
    ext_addr  = 32'h300;
    go();
    go();
    settle();
    chk("t1_mem_en", 32'(mem_en), 0);
    chk("t1_core_done", 32'(core_done), 0);
    chk("t1_ext_done", 32'(ext_done), 0);
    chk("t1_ext_gnt", 32'(ext_gnt), 0);
    chk("t1_mem_addr", mem_addr, 0);
    chk("t1_core_rdata", core_rdata, 0);
    chk("t1_ext_rdata", ext_rdata, 0);
    reset = 1'b0;
    push(1'b0, 1'b1, 32'hDEADBEEF);
    go(); settle();
    chk("t1_c1_mem_en", 32'(mem_en), 1);
    chk("t1_c1_ext_gnt", 32'(ext_gnt), 0);
    chk("t1_c1_mem_addr", mem_addr, 32'h100);
    ext_req = 1'b0;
    go(); go(); settle();
    chk("t1_c3_core_done", 32'(core_done), 1);
    core_req = 1'b0;

    // Single core load, latency 2.
    rst();
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 32'h100;
    push(1'b0, 1'b1, 32'hDEADBEEF);
    settle();
    chk("t2_c0_stall", 32'(core_stall), 1);
    chk("t2_c0_mem_en", 32'(mem_en), 0);
    for (int c = 1; c <= 2; c++) begin
      go(); settle();
      chk("t2_stall", 32'(core_stall), 1);
      chk("t2_mem_en", 32'(mem_en), 1);
      chk("t2_mem_addr", mem_addr, 32'h100);
      chk("t2_mem_we", 32'(mem_we), 0);
      chk("t2_core_done", 32'(core_done), 0);
    end
    go(); settle();
    chk("t2_c3_done", 32'(core_done), 1);
    chk("t2_c3_rdata", core_rdata, 32'hDEADBEEF);
    chk("t2_c3_stall", 32'(core_stall), 0);
    chk("t2_c3_mem_en", 32'(mem_en), 0);
    core_req = 1'b0;

    // Core store and ext load raised together.
    rst();
    core_req   = 1'b1;
    core_we    = 1'b1;
    core_addr  = 32'h200;
    core_wdata = 32'h12345678;
    core_mask  = 4'hF;
    ext_req    = 1'b1;
    ext_we     = 1'b0;
    ext_addr   = 32'h300;
    push(1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b1, 32'hCAFEF00D);
    for (int c = 1; c <= 2; c++) begin
      go(); settle();
      chk("t3_core_mem_en", 32'(mem_en), 1);
      chk("t3_core_mem_we", 32'(mem_we), 1);
      chk("t3_core_addr", mem_addr, 32'h200);
      chk("t3_core_wdata", mem_wdata, 32'h12345678);
      chk("t3_core_mask", 32'(mem_mask), 32'hF);
      chk("t3_core_ext_gnt", 32'(ext_gnt), 0);
    end
    go(); settle();
    chk("t3_c3_core_done", 32'(core_done), 1);
    chk("t3_c3_mem_en", 32'(mem_en), 0);
    core_req = 1'b0;
    core_we  = 1'b0;
    for (int c = 4; c <= 5; c++) begin
      go(); settle();
      chk("t3_ext_gnt", 32'(ext_gnt), 1);
      chk("t3_ext_addr", mem_addr, 32'h300);
      chk("t3_ext_we", 32'(mem_we), 0);
      chk("t3_ext_stall", 32'(core_stall), 0);
    end
    go(); settle();
    chk("t3_c6_ext_done", 32'(ext_done), 1);
    chk("t3_c6_ext_rdata", ext_rdata, 32'hCAFEF00D);
    ext_req = 1'b0;

    // Continuous contention: CORE, EXT, CORE, EXT back to back.
    rst();
    core_req  = 1'b1;
    core_addr = 32'h400;
    ext_req   = 1'b1;
    ext_addr  = 32'h500;
    push(1'b0, 1'b1, 32'h0BADC0DE);
    push(1'b1, 1'b1, 32'h55555555);
    push(1'b0, 1'b1, 32'h0BADC0DE);
    push(1'b1, 1'b1, 32'h55555555);
    for (int c = 1; c <= 12; c++) begin
      logic is_ext;
      logic is_done;
      is_ext  = (((c - 1) / 3) % 2) == 1;
      is_done = ((c - 1) % 3) == 2;
      go(); settle();
      chk("t4_mem_en", 32'(mem_en), 32'(!is_done));
      chk("t4_ext_gnt", 32'(ext_gnt), 32'(!is_done && is_ext));
      chk("t4_core_done", 32'(core_done), 32'(is_done && !is_ext));
      chk("t4_ext_done", 32'(ext_done), 32'(is_done && is_ext));
    end
    core_req = 1'b0;
    ext_req  = 1'b0;

    // Reset during ext ACCESS aborts without done.
    rst();
    ext_req  = 1'b1;
    ext_addr = 32'h300;
    go(); settle();
    chk("t5_c1_ext_gnt", 32'(ext_gnt), 1);
    chk("t5_c1_mem_en", 32'(mem_en), 1);
    reset   = 1'b1;
    ext_req = 1'b0;
    go(); settle();
    chk("t5_c2_mem_en", 32'(mem_en), 0);
    chk("t5_c2_ext_done", 32'(ext_done), 0);
    chk("t5_c2_ext_rdata", ext_rdata, 0);
    reset = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      go(); settle();
      chk("t5_ext_done", 32'(ext_done), 0);
      chk("t5_ext_rdata", ext_rdata, 0);
    end

    // Address change after grant is ignored.
    rst();
    core_req  = 1'b1;
    core_addr = 32'h400;
    push(1'b0, 1'b1, 32'h0BADC0DE);
    go(); settle();
    core_addr = 32'h500;
    chk("t6_c1_addr", mem_addr, 32'h400);
    go(); settle();
    chk("t6_c2_addr", mem_addr, 32'h400);
    go(); settle();
    chk("t6_c3_done", 32'(core_done), 1);
    chk("t6_c3_rdata", core_rdata, 32'h0BADC0DE);
    core_req = 1'b0;
    go(); go(); settle();
    chk("t6_rdata_hold", core_rdata, 32'h0BADC0DE);
    chk("t6_idle_mem_en", 32'(mem_en), 0);

    go(); settle();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
